// File: rtl/tanh_forward_block.sv
// rtl/tanh_forward_block.sv - piecewise-linear tanh over a vector, one element per cycle
//
// Purpose: applies a 9-point PWL tanh to HID_DIM signed fixed-point elements
// through a 3-stage pipeline. Produces q (N_LEN/F_LEN) for the next layer and
// q_forward (N_LEN_W/F_LEN_W), the wide copy kept for the backward pass.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active low
//   run        hold high for the whole operation; d stable while high
//   d          input vector, element i at d[i*N_LEN +: N_LEN]
//   valid      all HID_DIM results written and stable (combinational on run)
//   q          tanh(d), element i at q[i*N_LEN +: N_LEN]
//   q_forward  tanh(d), element i at q_forward[i*N_LEN_W +: N_LEN_W]
module tanh_forward_block #(
    parameter int HID_DIM = 24,
    parameter int N_LEN   = 16,
    parameter int F_LEN   = 8,
    parameter int N_LEN_W = 24,
    parameter int F_LEN_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic [HID_DIM*N_LEN-1:0]   d,
    output logic                       valid,
    output logic [HID_DIM*N_LEN-1:0]   q,
    output logic [HID_DIM*N_LEN_W-1:0] q_forward
);

    localparam int AW = N_LEN - 1;     // magnitude width
    localparam int FW = F_LEN - 1;     // fraction within a 0.5-wide segment
    localparam int KW = N_LEN - F_LEN; // segment index width
    localparam int TW = N_LEN_W;
    localparam int SH = F_LEN_W - F_LEN;
    localparam logic [4:0] LAST = 5'(HID_DIM - 1);

    // tanh(k/2) * 2^F_LEN_W, k = 0..8
    localparam logic [TW-1:0] T [0:8] = '{
        TW'(0),     TW'(30285), TW'(49912), TW'(59320), TW'(63178),
        TW'(64659), TW'(65212), TW'(65417), TW'(65492)
    };

    logic [4:0] cnt;
    logic [4:0] cnt_d [0:2];

    // Stage occupancy flags: a re-armed run must not write stale stage data.
    logic          v1, v2;
    logic          s1_s, s2_s;
    logic [KW-1:0] s1_k;
    logic [FW-1:0] s1_f;
    logic [TW-1:0] s2_y;

    // Stage 1 combinational: element select and saturating magnitude
    logic [N_LEN-1:0] x, x_neg;
    logic [AW-1:0]    a;

    always_comb begin
        x     = d[cnt*N_LEN +: N_LEN];
        x_neg = -x;
        if (!x[N_LEN-1])
            a = x[AW-1:0];
        else if (x == {1'b1, {AW{1'b0}}})
            a = {AW{1'b1}};  // |most negative| does not fit; clamp to max
        else
            a = x_neg[AW-1:0];
    end

    // Stage 2 combinational: table interpolation
    logic [3:0]       lo_idx, hi_idx;
    logic [TW-1:0]    t_lo, t_hi, diff, y_n;
    logic [TW+FW-1:0] prod;

    always_comb begin
        lo_idx = {1'b0, s1_k[2:0]};
        hi_idx = lo_idx + 4'd1;
        t_lo   = T[lo_idx];
        t_hi   = T[hi_idx];
        diff   = t_hi - t_lo;
        prod   = (TW+FW)'(diff) * (TW+FW)'(s1_f);
        if (32'(s1_k) >= 32'd8)
            y_n = T[8];
        else
            y_n = t_lo + prod[TW+FW-1:FW];
    end

    // Stage 3 combinational: sign restore and narrowing
    logic signed [TW-1:0] qf_n, q_sh;
    logic [N_LEN-1:0]     q_n;
    logic                 wr;

    always_comb begin
        qf_n  = s2_s ? -$signed(s2_y) : $signed(s2_y);
        q_sh  = qf_n >>> SH;
        q_n   = q_sh[N_LEN-1:0];
        valid = run & (cnt_d[2] == LAST);
        wr    = run & ~valid & v2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            cnt_d[0] <= '0;
            cnt_d[1] <= '0;
            cnt_d[2] <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            s1_s     <= 1'b0;
            s1_k     <= '0;
            s1_f     <= '0;
            s2_s     <= 1'b0;
            s2_y     <= '0;
        end else if (!run) begin
            cnt      <= '0;
            cnt_d[0] <= '0;
            cnt_d[1] <= '0;
            cnt_d[2] <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
        end else begin
            if (cnt != LAST)
                cnt <= cnt + 5'd1;
            cnt_d[0] <= cnt;
            cnt_d[1] <= cnt_d[0];
            cnt_d[2] <= cnt_d[1];
            v1       <= 1'b1;
            v2       <= v1;
            s1_s     <= x[N_LEN-1];
            s1_k     <= a[AW-1:FW];
            s1_f     <= a[FW-1:0];
            s2_s     <= s1_s;
            s2_y     <= y_n;
        end
    end

    // Results persist across run=0 for the backward block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            q_forward <= '0;
        end else if (wr) begin
            q[cnt_d[1]*N_LEN +: N_LEN]           <= q_n;
            q_forward[cnt_d[1]*N_LEN_W +: N_LEN_W] <= qf_n;
        end
    end

endmodule
